// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB first, followed by GAP idle cycles.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam bit             HAS_GAP  = (GAP > 0);
    localparam logic [3:0]     GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_last;
    logic             r_busy;

    logic             w_ready;
    logic             w_accept;

    // Ready also opens in the final cycle of a frame (GAP=0) or of the gap,
    // so back-to-back frames need no extra IDLE cycle.
    assign w_ready = (r_state == ST_IDLE)
                  || ((r_state == ST_SHIFT) && (r_bit_cnt == CNT_ZERO) && !HAS_GAP)
                  || ((r_state == ST_GAP) && (r_gap_cnt == 4'd0));
    assign w_accept   = data_valid && w_ready;
    assign data_ready = w_ready;

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign last    = r_last;
    assign busy    = r_busy;

    // State machine; output registers hold the value for the coming cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= {WIDTH{1'b0}};
            r_bit_cnt <= CNT_ZERO;
            r_gap_cnt <= 4'd0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_shift   <= {data_in[WIDTH-2:0], 1'b0};
            r_bit_cnt <= CNT_INIT;
            r_gap_cnt <= 4'd0;
            r_x       <= data_in[WIDTH-1];
            r_x_valid <= 1'b1;
            r_last    <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_last    <= 1'b0;
                    r_busy    <= 1'b0;
                end
                ST_SHIFT: begin
                    if (r_bit_cnt != CNT_ZERO) begin
                        r_x       <= r_shift[WIDTH-1];
                        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - CNT_ONE;
                        r_last    <= (r_bit_cnt == CNT_ONE);
                    end else begin
                        r_x       <= 1'b0;
                        r_x_valid <= 1'b0;
                        r_last    <= 1'b0;
                        if (HAS_GAP) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_INIT;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_shift   <= {WIDTH{1'b0}};
                    r_bit_cnt <= CNT_ZERO;
                    r_gap_cnt <= 4'd0;
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_last    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: one instance with GAP=1, one with
// GAP=0; serial bits are checked against a scoreboard queue.
module tb_serial_pattern_tx;

    typedef struct {
        logic x;
        logic last;
    } exp_bit_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;
        int         exp_busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] din1;
    logic       dv1;
    logic       rdy1, x1, xv1, last1, busy1;
    logic [7:0] din0;
    logic       dv0;
    logic       rdy0, x0, xv0, last0, busy0;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    exp_bit_t q1[$];
    exp_bit_t q0[$];

    serial_pattern_tx #(.WIDTH(8), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv1),
        .data_ready(rdy1), .x(x1), .x_valid(xv1), .last(last1), .busy(busy1)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
        .data_ready(rdy0), .x(x0), .x_valid(xv0), .last(last0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame1(input logic [7:0] bits);
        for (int i = 7; i >= 0; i--) q1.push_back('{x: bits[i], last: (i == 0)});
    endtask

    // Wait (bounded) for ready, then present one word for exactly one edge.
    task automatic send1(input logic [7:0] d, input logic [7:0] exp_bits);
        int n = 0;
        while (!rdy1 && n < 50) begin
            tick();
            n++;
        end
        chk("send1_ready_timeout", {31'd0, rdy1}, 32'd1);
        din1 = d;
        dv1  = 1'b1;
        push_frame1(exp_bits);
        tick();
        dv1  = 1'b0;
    endtask

    // Scoreboard monitor: pops one expected bit per x_valid cycle.
    always @(negedge clk) begin
        exp_bit_t e;
        if (mon_en) begin
            if (xv1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL dut1_unexpected_bit actual=x_valid=1 expected=x_valid=0 at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_x", {31'd0, x1}, {31'd0, e.x});
                    chk("dut1_last", {31'd0, last1}, {31'd0, e.last});
                end
            end else begin
                chk("dut1_idle_x", {31'd0, x1}, 32'd0);
                chk("dut1_idle_last", {31'd0, last1}, 32'd0);
            end
            if (xv0) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL dut0_unexpected_bit actual=x_valid=1 expected=x_valid=0 at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_x", {31'd0, x0}, {31'd0, e.x});
                    chk("dut0_last", {31'd0, last0}, {31'd0, e.last});
                end
            end else begin
                chk("dut0_idle_x", {31'd0, x0}, 32'd0);
                chk("dut0_idle_last", {31'd0, last0}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        int   nbusy;

        vecs[0] = '{data: 8'h3C, exp_bits: 8'b0011_1100, exp_busy: 9};
        vecs[1] = '{data: 8'h5A, exp_bits: 8'b0101_1010, exp_busy: 9};
        vecs[2] = '{data: 8'h01, exp_bits: 8'b0000_0001, exp_busy: 9};
        vecs[3] = '{data: 8'h80, exp_bits: 8'b1000_0000, exp_busy: 9};

        rst  = 1'b1;
        dv1  = 1'b0;
        din1 = 8'h00;
        dv0  = 1'b0;
        din0 = 8'h00;
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state held for 5 idle cycles
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_x", {31'd0, x1}, 32'd0);
            chk("rst_xv", {31'd0, xv1}, 32'd0);
            chk("rst_last", {31'd0, last1}, 32'd0);
            chk("rst_busy", {31'd0, busy1}, 32'd0);
            chk("rst_ready", {31'd0, rdy1}, 32'd1);
            chk("rst_busy0", {31'd0, busy0}, 32'd0);
            chk("rst_ready0", {31'd0, rdy0}, 32'd1);
            tick();
        end

        // 8'hB4 with GAP=1: timing of busy/ready/x_valid around the frame
        send1(8'hB4, 8'b1011_0100);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("b4_busy", {31'd0, busy1}, {31'd0, (k <= 9)});
            chk("b4_ready", {31'd0, rdy1}, {31'd0, (k >= 9)});
            chk("b4_xv", {31'd0, xv1}, {31'd0, (k <= 8)});
        end
        tick();

        // GAP=0: 8'hFF then 8'h00 back to back with data_valid held
        din0 = 8'hFF;
        dv0  = 1'b1;
        for (int i = 0; i < 8; i++) q0.push_back('{x: 1'b1, last: (i == 7)});
        for (int i = 0; i < 8; i++) q0.push_back('{x: 1'b0, last: (i == 7)});
        tick();
        din0 = 8'h00;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("b2b_xv", {31'd0, xv0}, {31'd0, (k <= 16)});
            chk("b2b_busy", {31'd0, busy0}, {31'd0, (k <= 16)});
            if (k == 8) begin
                @(posedge clk);
                #1;
                dv0 = 1'b0;
            end
        end
        tick();

        // data_in changes after accept must not affect the frame in flight
        send1(8'hA5, 8'b1010_0101);
        din1 = 8'h3C;
        for (int k = 0; k < 12; k++) tick();
        @(negedge clk);
        chk("a5_idle_busy", {31'd0, busy1}, 32'd0);
        chk("a5_sb_drained", q1.size(), 32'd0);
        tick();

        // Table-driven frames, each measured for busy length
        foreach (vecs[v]) begin
            send1(vecs[v].data, vecs[v].exp_bits);
            nbusy = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (busy1) nbusy++;
            end
            chk("vec_busy_len", nbusy, vecs[v].exp_busy);
            tick();
        end

        // Reset in the 4th bit cycle of 8'hC3 aborts without a last pulse
        din1 = 8'hC3;
        dv1  = 1'b1;
        q1.push_back('{x: 1'b1, last: 1'b0});
        q1.push_back('{x: 1'b1, last: 1'b0});
        q1.push_back('{x: 1'b0, last: 1'b0});
        q1.push_back('{x: 1'b0, last: 1'b0});
        tick();
        dv1 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_x", {31'd0, x1}, 32'd0);
        chk("abort_xv", {31'd0, xv1}, 32'd0);
        chk("abort_last", {31'd0, last1}, 32'd0);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_ready", {31'd0, rdy1}, 32'd1);
        chk("abort_sb", q1.size(), 32'd0);
        tick();
        send1(8'h81, 8'b1000_0001);
        for (int k = 0; k < 12; k++) tick();

        // rst and data_valid on the same edge: nothing starts
        rst  = 1'b1;
        dv1  = 1'b1;
        din1 = 8'hFF;
        tick();
        rst = 1'b0;
        dv1 = 1'b0;
        @(negedge clk);
        chk("rstdv_busy", {31'd0, busy1}, 32'd0);
        chk("rstdv_xv", {31'd0, xv1}, 32'd0);
        for (int k = 0; k < 4; k++) tick();

        chk("end_sb1_empty", q1.size(), 32'd0);
        chk("end_sb0_empty", q0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
